// File: rtl/elu_layer_driver.sv
// rtl/elu_layer_driver.sv - ELU layer load/valid initiator with frame gather and result drain
//
// Gathers CHUNKS chunks of LANES*DATA_LEN bits from an upstream valid/ready
// stream into a frame buffer and presents the whole frame on layer_d. It holds
// load high until the layer answers with layer_valid, captures layer_q into the
// same buffer, then streams the result out chunk by chunk over valid/ready.
//
// Optional feature macro: ELU_TIMEOUT_EN (RUN watchdog, sticky timeout_err).
//
// Ports:
//   clk          in   1                       clock, posedge
//   rst          in   1                       synchronous reset, active-high
//   in_valid     in   1                       upstream chunk valid
//   in_ready     out  1                       upstream chunk accepted (FILL)
//   in_data      in   LANES*DATA_LEN          upstream chunk
//   load         out  1                       registered layer run request
//   layer_d      out  CHUNKS*LANES*DATA_LEN   frame to layer, chunk k at k*CW
//   layer_valid  in   1                       layer done (sampled in RUN only)
//   layer_q      in   CHUNKS*LANES*DATA_LEN   layer result, same packing
//   out_valid    out  1                       result chunk valid (DRAIN)
//   out_ready    in   1                       downstream accepts result chunk
//   out_data     out  LANES*DATA_LEN          result chunk
//   busy         out  1                       high in RUN or DRAIN
//   timeout_err  out  1                       sticky watchdog flag

module elu_layer_driver #(
  parameter int DATA_LEN       = 16,
  parameter int LANES          = 12,
  parameter int CHUNKS         = 32,
  parameter int TIMEOUT_CYCLES = 128
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [LANES*DATA_LEN-1:0]         in_data,
  output logic                              load,
  output logic [CHUNKS*LANES*DATA_LEN-1:0]  layer_d,
  input  logic                              layer_valid,
  input  logic [CHUNKS*LANES*DATA_LEN-1:0]  layer_q,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [LANES*DATA_LEN-1:0]         out_data,
  output logic                              busy,
  output logic                              timeout_err
);

  localparam int CW = LANES * DATA_LEN;
  localparam int IW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(CHUNKS - 1);

  if (CHUNKS < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("elu_layer_driver: CHUNKS must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [IW-1:0]   wr_idx;
  logic [IW-1:0]   rd_idx;
  logic [CW-1:0]   frame_buf [CHUNKS];

  logic            in_accept;
  logic            out_accept;
  logic            layer_done;
  logic            tmo_hit;

  assign in_accept  = in_valid && in_ready;
  assign out_accept = out_valid && out_ready;
  // layer_valid only means something while a run is outstanding
  assign layer_done = (state == S_RUN) && layer_valid;

  // ---------------------------------------------------------------------------
  // Watchdog on the RUN wait
  // ---------------------------------------------------------------------------
`ifdef ELU_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_cnt;
  logic          tmo_flag;

  // Held at zero outside RUN, so it is already clear on the first RUN cycle.
  always_ff @(posedge clk) begin
    if (rst || state != S_RUN) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != TMO_LAST) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // A layer_valid arriving on the very last allowed cycle still counts as done.
  assign tmo_hit = (state == S_RUN) && !layer_valid && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_flag <= 1'b0;
    end else if (tmo_hit) begin
      tmo_flag <= 1'b1;
    end
  end

  assign timeout_err = tmo_flag;
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FILL;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      S_FILL: begin
        if (in_accept && wr_idx == LAST_IDX) begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (layer_done) begin
          state_next = S_DRAIN;
        end else if (tmo_hit) begin
          state_next = S_FILL;
        end
      end
      S_DRAIN: begin
        if (out_accept && rd_idx == LAST_IDX) begin
          state_next = S_FILL;
        end
      end
      default: state_next = S_FILL;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs decoded from state
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      S_FILL:  in_ready = 1'b1;
      S_RUN:   busy = 1'b1;
      S_DRAIN: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // load is registered off the next state: it rises the cycle after the last
  // accept and falls the cycle after layer_valid, timeout or reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      load <= 1'b0;
    end else begin
      load <= (state_next == S_RUN);
    end
  end

  // ---------------------------------------------------------------------------
  // Chunk indices
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx <= '0;
      rd_idx <= '0;
    end else begin
      if (in_accept) begin
        wr_idx <= (wr_idx == LAST_IDX) ? '0 : wr_idx + 1'b1;
      end
      if (layer_done) begin
        rd_idx <= '0;
      end else if (out_accept) begin
        rd_idx <= (rd_idx == LAST_IDX) ? '0 : rd_idx + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame buffer: gathered input, then overwritten in place by the result.
  // No reset; contents are only meaningful after a full fill.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (in_accept) begin
        frame_buf[wr_idx] <= in_data;
      end else if (layer_done) begin
        for (int k = 0; k < CHUNKS; k++) begin
          frame_buf[k] <= layer_q[k*CW +: CW];
        end
      end
    end
  end

  for (genvar g = 0; g < CHUNKS; g++) begin : g_layer_d
    assign layer_d[g*CW +: CW] = frame_buf[g];
  end

  assign out_data = frame_buf[rd_idx];

endmodule

// File: tb/tb_elu_layer_driver.sv
// tb/tb_elu_layer_driver.sv - directed self-checking bench for elu_layer_driver

module tb_elu_layer_driver;

  localparam int DL  = 16;
  localparam int LN  = 12;
  localparam int CH  = 32;
  localparam int CW  = DL * LN;
  localparam int LAT = 37;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [CW-1:0]     in_data;
  logic              load;
  logic [CH*CW-1:0]  layer_d;
  logic              layer_valid;
  logic [CH*CW-1:0]  layer_q;
  logic              out_valid;
  logic              out_ready;
  logic [CW-1:0]     out_data;
  logic              busy;
  logic              timeout_err;

  int checks   = 0;
  int failures = 0;

  logic [DL-1:0] fv [CH];

  elu_layer_driver #(
    .DATA_LEN(DL), .LANES(LN), .CHUNKS(CH), .TIMEOUT_CYCLES(128)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .load(load), .layer_d(layer_d), .layer_valid(layer_valid), .layer_q(layer_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] chunk_of(input logic [DL-1:0] v);
    return {LN{v}};
  endfunction

  task automatic set_fv(input int base, input int step);
    for (int k = 0; k < CH; k++) fv[k] = DL'(base + k * step);
  endtask

  // Starts and ends at a negedge. n < CH leaves a partial frame.
  task automatic fill(input int n, input bit glitch, input string tag);
    int bad = 0;
    for (int k = 0; k < n; k++) begin
      if (load !== 1'b0 || in_ready !== 1'b1) bad++;
      in_valid    = 1'b1;
      in_data     = chunk_of(fv[k]);
      layer_valid = glitch && (k == 5);
      layer_q     = (glitch && k == 5) ? '1 : '0;
      @(negedge clk);
    end
    in_valid    = 1'b0;
    layer_valid = 1'b0;
    layer_q     = '0;
    check({tag, " load low/in_ready high during fill"}, bad, 0);
    if (n == CH) begin
      check({tag, " load after last accept"}, load, 1);
      check({tag, " in_ready in RUN"}, in_ready, 0);
      check({tag, " busy in RUN"}, busy, 1);
    end
  endtask

  task automatic check_frame(input string tag);
    for (int k = 0; k < CH; k++)
      check($sformatf("%s layer_d chunk %0d", tag, k), layer_d[k*CW +: CW], chunk_of(fv[k]));
  endtask

  // Layer model: q = d + 1 per element, answered LAT cycles after load rise.
  task automatic run_layer(input string tag);
    repeat (LAT - 1) @(negedge clk);
    check({tag, " load held in RUN"}, {load, out_valid}, 2'b10);
    for (int k = 0; k < CH; k++) layer_q[k*CW +: CW] = chunk_of(fv[k] + 1'b1);
    layer_valid = 1'b1;
    @(negedge clk);
    layer_valid = 1'b0;
    layer_q     = '0;
    check({tag, " load dropped after layer_valid"}, load, 0);
    check({tag, " out_valid in DRAIN"}, out_valid, 1);
  endtask

  task automatic drain(input bit toggle, input bit glitch, input string tag);
    int k   = 0;
    int cyc = 0;
    while (k < CH && cyc < 4 * CH) begin
      out_ready   = toggle ? ~cyc[0] : 1'b1;
      check($sformatf("%s out chunk %0d cyc %0d", tag, k, cyc),
            {out_valid, out_data}, {1'b1, chunk_of(fv[k] + 1'b1)});
      if (out_ready) k++;
      layer_valid = glitch && (cyc == 3);
      layer_q     = (glitch && cyc == 3) ? '1 : '0;
      cyc++;
      @(negedge clk);
    end
    out_ready   = 1'b0;
    layer_valid = 1'b0;
    layer_q     = '0;
    check({tag, " drain cycles"}, cyc, toggle ? 2 * CH - 1 : CH);
    check({tag, " back to FILL"}, {in_ready, out_valid, busy, load}, 4'b1000);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    layer_valid = 1'b0; layer_q = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset in_ready", in_ready, 1);
    check("reset load/out_valid/busy", {load, out_valid, busy}, 3'b000);
    check("reset timeout_err", timeout_err, 0);

    // Frame 1: chunk k = k, outputs 1..32 with out_ready held high
    set_fv(0, 1);
    fill(CH, 1'b0, "f1");
    check("f1 layer_d chunk 31", layer_d[31*CW +: CW], chunk_of(16'd31));
    check_frame("f1");
    run_layer("f1");
    drain(1'b0, 1'b0, "f1");

    // Frame 2: out_ready toggled every cycle
    set_fv(16'h0500, 3);
    fill(CH, 1'b0, "f2");
    run_layer("f2");
    drain(1'b1, 1'b0, "f2");

    // Reset after 10 chunks, then a complete new frame
    set_fv(16'h0a00, 1);
    fill(10, 1'b0, "f3a");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("f3 after rst", {in_ready, load, busy}, 3'b100);
    set_fv(16'h0c00, 7);
    fill(CH, 1'b0, "f3");
    check_frame("f3");
    run_layer("f3");
    drain(1'b0, 1'b0, "f3");

    // layer_valid pulses during FILL and DRAIN must be ignored
    set_fv(16'h0e00, 5);
    fill(CH, 1'b1, "f4");
    check_frame("f4");
    run_layer("f4");
    drain(1'b1, 1'b1, "f4");

`ifdef ELU_TIMEOUT_EN
    set_fv(1, 1);
    fill(CH, 1'b0, "to");
    repeat (127) @(negedge clk);
    check("to RUN cycle 128", {load, timeout_err, in_ready}, 3'b100);
    @(negedge clk);
    check("to fired", {timeout_err, load, in_ready, out_valid}, 4'b1010);
    repeat (5) @(negedge clk);
    check("to sticky", {timeout_err, out_valid}, 2'b10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("to cleared by rst", timeout_err, 0);
`else
    check("timeout_err tied low", timeout_err, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
